osc_clkgen_mc: RTL and testbench

- Multi-channel programmable clock-enable generator in the fabric, clocked from the on-chip 50 MHz RC oscillator.
- Replaces the fixed single-frequency oscillator output with NUM_CH independently divided outputs. Each channel produces:
  - a one-cycle TICK strobe;
  - a registered 50% duty SQ square wave.
- Divisors are runtime-programmable, glitch-free: new values apply only at a terminal count.
- A global SYNC realigns all channels.

---
 rtl/osc_clkgen_mc.sv | 108 ++++++++++
 tb/tb_osc_clkgen_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_clkgen_mc.sv
`default_nettype none
// ============================================================================
// Module      : osc_clkgen_mc
// Description : Multi-channel programmable clock-enable generator. Each
//               channel divides the fabric clock by a runtime-programmable
//               divisor and produces a one-cycle tick strobe plus a 50% duty
//               square wave. Divisor changes on a running channel wait for a
//               terminal count so no period is ever truncated. A global sync
//               pulse restarts every running channel phase-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module osc_clkgen_mc #(
    parameter int NUM_CH      = 4,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 50,
    parameter int CH_SEL_W    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    en,
    input  logic                 sync,
    input  logic                 wr_en,
    input  logic [CH_SEL_W-1:0]  wr_ch,
    input  logic [DIV_WIDTH-1:0] wr_div,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    sq,
    output logic [NUM_CH-1:0]    pending
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    // Reload value for the down-counter: a divisor of 0 behaves as 1,
    // so both 0 and 1 reload to 0 (terminal count every cycle).
    function automatic logic [DIV_WIDTH-1:0] eff_m1(input logic [DIV_WIDTH-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_WIDTH-1:0] div_act;
        logic [DIV_WIDTH-1:0] div_pend;
        logic                 pend;
        logic [DIV_WIDTH-1:0] cnt;
        logic                 tick_q;
        logic                 sq_q;
        logic                 sel;
        logic [DIV_WIDTH-1:0] reload_div;

        // Write addressed to this channel; out-of-range channel numbers
        // never match any generated index, so they are ignored naturally.
        assign sel        = wr_en && (wr_ch == CH_SEL_W'(i));
        // Divisor that takes effect at the next reload point
        // (the value pending before this edge's write, if any).
        assign reload_div = pend ? div_pend : div_act;

        // Per-channel divider: reset, idle, sync, terminal count, count down.
        always_ff @(posedge clk) begin
            if (reset) begin
                div_act  <= DEF_DIV;
                div_pend <= '0;
                pend     <= 1'b0;
                cnt      <= eff_m1(DEF_DIV);
                tick_q   <= 1'b0;
                sq_q     <= 1'b0;
            end else if (!en[i]) begin
                // Idle: hold a full period ready so restart is clean.
                tick_q <= 1'b0;
                sq_q   <= 1'b0;
                pend   <= 1'b0;
                if (sel) begin
                    div_act <= wr_div;
                    cnt     <= eff_m1(wr_div);
                end else begin
                    div_act <= reload_div;
                    cnt     <= eff_m1(reload_div);
                end
            end else begin
                if (sync) begin
                    div_act <= reload_div;
                    pend    <= 1'b0;
                    cnt     <= eff_m1(reload_div);
                    tick_q  <= 1'b0;
                    sq_q    <= 1'b0;
                end else if (cnt == '0) begin
                    tick_q  <= 1'b1;
                    sq_q    <= ~sq_q;
                    div_act <= reload_div;
                    pend    <= 1'b0;
                    cnt     <= eff_m1(reload_div);
                end else begin
                    cnt    <= cnt - 1'b1;
                    tick_q <= 1'b0;
                end
                // A write on a running channel always becomes pending, even
                // on a reload edge: the reload above used the older value.
                if (sel) begin
                    div_pend <= wr_div;
                    pend     <= 1'b1;
                end
            end
        end

        assign tick[i]    = tick_q;
        assign sq[i]      = sq_q;
        assign pending[i] = pend;
    end

endmodule
`default_nettype wire

// File: tb/tb_osc_clkgen_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_osc_clkgen_mc
// Description : Self-checking bench for osc_clkgen_mc: vector table, directed
//               multi-cycle sequences and randomized traffic against a
//               period-elapsed reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osc_clkgen_mc;
    localparam int NUM_CH      = 4;
    localparam int DIV_WIDTH   = 16;
    localparam int DEFAULT_DIV = 50;
    localparam int CH_SEL_W    = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NUM_CH-1:0]    en = '0;
    logic                 sync = 1'b0;
    logic                 wr_en = 1'b0;
    logic [CH_SEL_W-1:0]  wr_ch = '0;
    logic [DIV_WIDTH-1:0] wr_div = '0;
    logic [NUM_CH-1:0]    tick, sq, pending;

    int checks = 0;
    int failures = 0;

    osc_clkgen_mc #(
        .NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV), .CH_SEL_W(CH_SEL_W)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .tick(tick), .sq(sq), .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference model: per channel, active/pending divisor and the number of
    // edges elapsed in the current period. A period ends once eff(div) edges
    // have passed since it began.
    int          m_act [NUM_CH];
    int          m_pdiv[NUM_CH];
    bit          m_pend[NUM_CH];
    int          m_el  [NUM_CH];
    logic [NUM_CH-1:0] m_tick = '0, m_sq = '0, m_pnd = '0;

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic model_edge();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            bit hit;
            hit = wr_en && (int'(wr_ch) == ch);
            if (reset) begin
                m_act[ch] = DEFAULT_DIV; m_pdiv[ch] = 0; m_pend[ch] = 0;
                m_el[ch] = 0; m_tick[ch] = 0; m_sq[ch] = 0;
            end else if (!en[ch]) begin
                if (m_pend[ch]) m_act[ch] = m_pdiv[ch];
                m_pend[ch] = 0;
                if (hit) m_act[ch] = int'(wr_div);
                m_el[ch] = 0; m_tick[ch] = 0; m_sq[ch] = 0;
            end else begin
                if (sync) begin
                    if (m_pend[ch]) m_act[ch] = m_pdiv[ch];
                    m_pend[ch] = 0;
                    m_el[ch] = 0; m_tick[ch] = 0; m_sq[ch] = 0;
                end else if (m_el[ch] + 1 == eff(m_act[ch])) begin
                    m_tick[ch] = 1; m_sq[ch] = ~m_sq[ch];
                    if (m_pend[ch]) m_act[ch] = m_pdiv[ch];
                    m_pend[ch] = 0;
                    m_el[ch] = 0;
                end else begin
                    m_el[ch]++; m_tick[ch] = 0;
                end
                if (hit) begin
                    m_pdiv[ch] = int'(wr_div); m_pend[ch] = 1;
                end
            end
            m_pnd[ch] = m_pend[ch];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: model follows the same inputs, outputs compared #1 later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk($sformatf("%s_tick", tag), 32'(tick), 32'(m_tick));
        chk($sformatf("%s_sq", tag), 32'(sq), 32'(m_sq));
        chk($sformatf("%s_pend", tag), 32'(pending), 32'(m_pnd));
    endtask

    task automatic idle_inputs();
        reset = 0; sync = 0; wr_en = 0; wr_ch = '0; wr_div = '0;
    endtask

    task automatic do_reset();
        idle_inputs(); reset = 1; cycle("rst"); reset = 0;
    endtask

    task automatic wr(input int ch, input int d);
        wr_en = 1; wr_ch = CH_SEL_W'(ch); wr_div = DIV_WIDTH'(d);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  en;
        logic        sy;
        logic        we;
        logic [3:0]  wch;
        logic [15:0] wdiv;
        logic [3:0]  et;
        logic [3:0]  es;
        logic [3:0]  ep;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n, t0, t1;
        // Vectors: ch2 divisor 0 then 1 while idle, run, a write on a terminal
        // edge, a pending switch to 2, an out-of-range write, then stop.
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'd2, 16'd0, 4'b0000, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'd2, 16'd1, 4'b0000, 4'b0000, 4'b0000};
        tbl[3]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0100, 4'b0100, 4'b0000};
        tbl[4]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0100, 4'b0000, 4'b0000};
        tbl[5]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'd7, 16'd3, 4'b0100, 4'b0100, 4'b0000};
        tbl[6]  = '{1'b0, 4'b0100, 1'b0, 1'b1, 4'd2, 16'd2, 4'b0100, 4'b0000, 4'b0100};
        tbl[7]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0100, 4'b0100, 4'b0000};
        tbl[8]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0100, 4'b0000};
        tbl[9]  = '{1'b0, 4'b0100, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0100, 4'b0000, 4'b0000};
        tbl[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'd0, 16'd0, 4'b0000, 4'b0000, 4'b0000};

        for (int v = 0; v < 11; v++) begin
            reset = tbl[v].rst; en = tbl[v].en; sync = tbl[v].sy;
            wr_en = tbl[v].we; wr_ch = tbl[v].wch; wr_div = tbl[v].wdiv;
            cycle($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_tick_tbl", v), 32'(tick), 32'(tbl[v].et));
            chk($sformatf("vec%0d_sq_tbl", v), 32'(sq), 32'(tbl[v].es));
            chk($sformatf("vec%0d_pend_tbl", v), 32'(pending), 32'(tbl[v].ep));
        end
        idle_inputs();

        // Default divisor: first tick 50 edges after enable, then every 50.
        en = '0; do_reset();
        en = 4'b0001;
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            cycle("def"); n = k;
            if (tick[0]) break;
        end
        chk("def_first_tick", n, 50);
        chk("def_sq_high", 32'(sq[0]), 1);
        chk("def_other_ticks", 32'(tick[3:1]), 0);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            cycle("def2"); n = k;
            if (tick[0]) break;
        end
        chk("def_period", n, 50);
        chk("def_sq_low", 32'(sq[0]), 0);

        // Ch1 at 10, write 4 mid-period: current period keeps 10, then 4.
        en = '0; do_reset();
        wr(1, 10); cycle("ch1_wr"); idle_inputs();
        en = 4'b0010;
        for (int k = 1; k <= 40; k++) begin
            cycle("ch1_a");
            if (tick[1]) break;
        end
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) wr(1, 4);
            cycle("ch1_b"); idle_inputs(); n = k;
            if (k == 5) chk("ch1_pend_set", 32'(pending[1]), 1);
            if (tick[1]) break;
        end
        chk("ch1_old_period", n, 10);
        chk("ch1_pend_clr", 32'(pending[1]), 0);
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            cycle("ch1_c"); n = k;
            if (tick[1]) break;
        end
        chk("ch1_new_period", n, 4);

        // Sync: ch0 div 3, ch1 div 5; both restart aligned.
        en = '0; do_reset();
        wr(0, 3); cycle("sy_w0"); wr(1, 5); cycle("sy_w1"); idle_inputs();
        en = 4'b0011;
        for (int k = 0; k < 7; k++) cycle("sy_run");
        sync = 1; cycle("sy_pulse"); sync = 0;
        chk("sy_sq_zero", 32'(sq[1:0]), 0);
        t0 = 0; t1 = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle("sy_after");
            if (tick[0] && t0 == 0) t0 = k;
            if (tick[1] && t1 == 0) t1 = k;
        end
        chk("sy_ch0_lat", t0, 3);
        chk("sy_ch1_lat", t1, 5);

        // Reset mid-period with a pending write, enable held high.
        wr(1, 9); cycle("rm_wr"); idle_inputs();
        chk("rm_pend", 32'(pending[1]), 1);
        reset = 1; cycle("rm_rst"); reset = 0;
        chk("rm_zero", {tick, sq, pending}, 0);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            cycle("rm_run"); n = k;
            if (tick[0]) break;
        end
        chk("rm_first_tick", n, 50);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 19) == 0) en = NUM_CH'($urandom);
            sync = ($urandom_range(0, 39) == 0);
            wr_en = ($urandom_range(0, 5) == 0);
            wr_ch = CH_SEL_W'($urandom_range(0, 7));
            wr_div = DIV_WIDTH'($urandom_range(0, 9));
            cycle("rnd");
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
